// File: rtl/wrr_arbiter_if.sv
// Request/grant bundle for wrr_arbiter. The master side drives requests and weights;
// the slave side (the arbiter) returns the registered grant.
interface wrr_arbiter_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned WW = 4
);
  localparam int unsigned IDW = $clog2(N);

  logic [N-1:0]    request_sig;
  logic [N*WW-1:0] weight;
  logic [N-1:0]    grant;
  logic            grant_valid;
  logic [IDW-1:0]  grant_id;

  modport master (
    output request_sig,
    output weight,
    input  grant,
    input  grant_valid,
    input  grant_id
  );

  modport slave (
    input  request_sig,
    input  weight,
    output grant,
    output grant_valid,
    output grant_id
  );
endinterface

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: each holder keeps a registered one-hot grant for weight+1
// cycles while requesting, then priority rotates starting after the last new grant.
module wrr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned WW = 4
) (
  input logic          clk,
  input logic          rstn,
  wrr_arbiter_if.slave bus
);
  localparam int unsigned IDW = $clog2(N);

  logic [N-1:0]   grant_q, grant_d;
  logic           grant_valid_q, grant_valid_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] last_id_q, last_id_d;
  logic [WW-1:0]  cnt_q, cnt_d;

  logic [WW-1:0]  holder_weight;
  logic           hold;
  logic           found;
  logic [IDW-1:0] win_id;
  int             k;

  // Holder's weight is read live so a reduced quota ends the burst on the next edge.
  always_comb begin
    holder_weight = bus.weight[grant_id_q*WW +: WW];
    hold          = grant_valid_q && bus.request_sig[grant_id_q] && (cnt_q < holder_weight);
  end

  // Rotating search from last_id+1; last_id itself is visited last.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    k      = 0;
    for (int i = 1; i <= int'(N); i++) begin
      k = (int'(last_id_q) + i) % int'(N);
      if (!found && bus.request_sig[k]) begin
        found  = 1'b1;
        win_id = IDW'(k);
      end
    end
  end

  always_comb begin
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    last_id_d     = last_id_q;
    cnt_d         = cnt_q;
    if (hold) begin
      cnt_d = cnt_q + WW'(1);
    end else if (found) begin
      grant_d         = '0;
      grant_d[win_id] = 1'b1;
      grant_valid_d   = 1'b1;
      grant_id_d      = win_id;
      last_id_d       = win_id;
      cnt_d           = '0;
    end else begin
      grant_d       = '0;
      grant_valid_d = 1'b0;
      grant_id_d    = '0;
      cnt_d         = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      last_id_q     <= IDW'(N - 1);
      cnt_q         <= '0;
    end else begin
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      last_id_q     <= last_id_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_id    = grant_id_q;
endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed bench for wrr_arbiter: a 4-way WW=4 instance and an 8-way WW=2 instance
// checked against hand-computed grant sequences.
module tb_wrr_arbiter;
  logic clk;
  logic rstn;
  int   n_vec;
  int   n_err;

  wrr_arbiter_if #(.N(4), .WW(4)) if4 ();
  wrr_arbiter_if #(.N(8), .WW(2)) if8 ();

  wrr_arbiter #(.N(4), .WW(4)) u_dut4 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (if4.slave)
  );

  wrr_arbiter #(.N(8), .WW(2)) u_dut8 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (if8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Expected id and valid are derived from the expected one-hot grant.
  task automatic expect_grant(input string tag, input logic [31:0] g, input logic [31:0] v,
                              input logic [31:0] id, input logic [31:0] eg);
    logic [31:0] eid;
    eid = 0;
    for (int i = 0; i < 32; i++) if (eg[i]) eid = i;
    check_eq({tag, ".grant"}, g, eg);
    check_eq({tag, ".valid"}, v, {31'd0, (eg != 0)});
    check_eq({tag, ".id"}, id, eid);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp4(input string tag, input logic [3:0] eg);
    expect_grant(tag, 32'(if4.grant), 32'(if4.grant_valid), 32'(if4.grant_id), 32'(eg));
  endtask

  task automatic exp8(input string tag, input logic [7:0] eg);
    expect_grant(tag, 32'(if8.grant), 32'(if8.grant_valid), 32'(if8.grant_id), 32'(eg));
  endtask

  logic [3:0] seq_rr [5]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] seq_w  [10] = '{4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b0100,
                              4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
  logic [7:0] seq_8  [4]  = '{8'h01, 8'h80, 8'h01, 8'h80};

  initial begin
    n_vec = 0;
    n_err = 0;
    rstn  = 1'b0;
    if4.request_sig = 4'b1111;
    if4.weight      = '0;
    if8.request_sig = '0;
    if8.weight      = '0;

    // Reset with requests already driven
    step();
    step();
    exp4("reset", 4'b0000);
    rstn = 1'b1;

    // Plain round robin; first search starts at index 0
    for (int i = 0; i < 5; i++) begin
      step();
      exp4($sformatf("rr%0d", i), seq_rr[i]);
    end

    // Weighted bursts: req0 already has its first cycle, w0=2 w1=0 w2=1 w3=0
    if4.weight = {4'd0, 4'd1, 4'd0, 4'd2};
    for (int i = 0; i < 10; i++) begin
      step();
      exp4($sformatf("wrr%0d", i), seq_w[i]);
    end

    // Early release: w0=3, w2=1
    if4.weight      = {4'd0, 4'd1, 4'd0, 4'd3};
    if4.request_sig = 4'b0001;
    step();
    exp4("early.first", 4'b0001);
    if4.request_sig = 4'b0101;
    step();
    exp4("early.second", 4'b0001);
    if4.request_sig = 4'b0100;
    step();
    exp4("early.handover", 4'b0100);
    // req2 keeps exactly 2 cycles only if cnt restarted at 0
    if4.request_sig = 4'b0101;
    step();
    exp4("early.cnt_hold", 4'b0100);
    step();
    exp4("early.cnt_rotate", 4'b0001);

    // Lone requester with w1=1: no idle gap across quota expiry
    if4.weight      = {4'd0, 4'd0, 4'd1, 4'd0};
    if4.request_sig = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      step();
      exp4($sformatf("lone%0d", i), 4'b0010);
    end
    if4.request_sig = 4'b0000;
    step();
    exp4("idle", 4'b0000);
    if4.request_sig = 4'b1001;
    step();
    exp4("after_idle", 4'b1000);

    // Asynchronous reset mid-burst
    if4.weight = {4'd3, 4'd0, 4'd0, 4'd0};
    step();
    exp4("burst_pre_reset", 4'b1000);
    #3;
    rstn = 1'b0;
    #1;
    exp4("async_reset", 4'b0000);
    if4.request_sig = 4'b1111;
    if4.weight      = '0;
    @(posedge clk);
    #1;
    exp4("reset_held", 4'b0000);
    rstn = 1'b1;
    step();
    exp4("post_reset", 4'b0001);

    // N=8, WW=2 instance
    if4.request_sig = 4'b0000;
    if8.request_sig = 8'h81;
    for (int i = 0; i < 4; i++) begin
      step();
      exp8($sformatf("n8_%0d", i), seq_8[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
